// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with a 2-flop input synchroniser and a
// first-word fall-through receive FIFO.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
    state_t        state, state_d;
    logic [1:0]    sync;
    logic          rx_s;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    idx, idx_d;
    logic [7:0]    shreg, shreg_d;
    logic          push, pop, full, wr_en;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    assign rx_s = sync[1];
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            sync  <= 2'b11;
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            sync  <= {sync[0], uart_rx};
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            shreg <= shreg_d;
        end
    end
    always_comb begin
        state_d   = state;
        cnt_d     = cnt + CW'(1);
        idx_d     = idx;
        shreg_d   = shreg;
        push      = 1'b0;
        frame_err = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: if (cnt == HALF) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt == LAST) begin
                cnt_d        = '0;
                shreg_d[idx] = rx_s;
                idx_d        = idx + 3'd1;
                if (idx == 3'd7) state_d = STOP;
            end
            STOP: if (cnt == LAST) begin
                cnt_d     = '0;
                push      = rx_s;
                frame_err = !rx_s;
                state_d   = rx_s ? IDLE : WAIT_HI;
            end
            WAIT_HI: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    assign rx_busy  = state != IDLE;
    assign rx_valid = count != '0;
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;
    assign pop      = rx_valid & rx_ready;
    assign full     = count == (AW + 1)'(FIFO_DEPTH);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign wr_en    = push & (!full | pop);
    assign overrun  = push & full & !pop;
    always_ff @(posedge clk_in) if (wr_en) mem[wr_ptr] <= shreg;
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW + 1)'(wr_en) - (AW + 1)'(pop);
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames at 16 clocks per bit covering glitches,
// framing errors, overrun, simultaneous push/pop and mid-frame reset.
module tb_uart_receiver;
    logic       clk_in = 1'b0;
    logic       reset_in = 1'b1;
    logic       uart_rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, rx_busy;
    int         n_checks = 0;
    int         n_fail = 0;
    int         valid_cycles, fe_cnt, ov_cnt, excl_bad;
    logic [7:0] got [$];
    uart_receiver #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .uart_rx(uart_rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
    );
    always #5 clk_in = ~clk_in;
    always @(negedge clk_in) begin
        if (rx_valid) valid_cycles++;
        if (rx_valid && rx_ready) got.push_back(rx_data);
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err && overrun) excl_bad++;
    end
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask
    task automatic clr();
        valid_cycles = 0;
        fe_cnt = 0;
        ov_cnt = 0;
        got.delete();
    endtask
    task automatic send(input logic [7:0] b, input logic stop_lvl);
        uart_rx = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(16);
        end
        uart_rx = stop_lvl;
        tick(16);
    endtask
    task automatic expect_got(input string tag, input logic [7:0] exp [$]);
        check({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s_%0d", tag, i), got[i], exp[i]);
    endtask
    initial begin
        clr();
        excl_bad = 0;
        tick(1);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_busy", rx_busy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        reset_in = 1'b0;
        tick(5);
        // 1: single byte with consumer always ready
        rx_ready = 1'b1;
        clr();
        send(8'hA5, 1'b1);
        tick(4);
        expect_got("t1_data", '{8'hA5});
        check("t1_valid_cycles", valid_cycles, 1);
        check("t1_ferr", fe_cnt, 0);
        check("t1_ovr", ov_cnt, 0);
        check("t1_busy", rx_busy, 0);
        // 2: short low glitch is rejected
        clr();
        uart_rx = 1'b0;
        tick(4);
        uart_rx = 1'b1;
        tick(20);
        check("t2_valid_cycles", valid_cycles, 0);
        check("t2_ferr", fe_cnt, 0);
        check("t2_busy", rx_busy, 0);
        send(8'h3C, 1'b1);
        tick(4);
        expect_got("t2_data", '{8'h3C});
        // 3: bad stop bit followed by a long break
        clr();
        send(8'h5A, 1'b0);
        tick(640);
        check("t3_busy_break", rx_busy, 1);
        check("t3_ferr", fe_cnt, 1);
        uart_rx = 1'b1;
        tick(32);
        check("t3_busy_idle", rx_busy, 0);
        send(8'h55, 1'b1);
        tick(4);
        expect_got("t3_data", '{8'h55});
        check("t3_ferr_total", fe_cnt, 1);
        // 4: overrun on fifth byte while consumer stalls
        rx_ready = 1'b0;
        clr();
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
        check("t4_ovr_full", ov_cnt, 0);
        send(8'h05, 1'b1);
        check("t4_ovr", ov_cnt, 1);
        check("t4_valid", rx_valid, 1);
        rx_ready = 1'b1;
        tick(10);
        expect_got("t4_drain", '{8'h01, 8'h02, 8'h03, 8'h04});
        check("t4_empty", rx_valid, 0);
        // 5: pop coincides with push into a full FIFO
        rx_ready = 1'b0;
        clr();
        for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 1'b1);
        uart_rx = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            uart_rx = 8'h15 >> i;
            tick(16);
        end
        uart_rx = 1'b1;
        tick(10);
        check("t5_busy_pre", rx_busy, 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("t5_ovr", ov_cnt, 0);
        check("t5_busy_post", rx_busy, 0);
        check("t5_still_valid", rx_valid, 1);
        tick(8);
        rx_ready = 1'b1;
        tick(10);
        expect_got("t5_drain", '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15});
        // 6: reset during data bit 3 with a byte waiting in the FIFO
        rx_ready = 1'b0;
        clr();
        send(8'h77, 1'b1);
        check("t6_pre_valid", rx_valid, 1);
        uart_rx = 1'b0;
        tick(16);
        for (int i = 0; i < 3; i++) begin
            uart_rx = 8'h96 >> i;
            tick(16);
        end
        uart_rx = 1'b0;
        tick(8);
        check("t6_busy_mid", rx_busy, 1);
        reset_in = 1'b1;
        #1;
        check("t6_rst_valid", rx_valid, 0);
        check("t6_rst_data", rx_data, 0);
        check("t6_rst_busy", rx_busy, 0);
        check("t6_rst_ferr", frame_err, 0);
        check("t6_rst_ovr", overrun, 0);
        uart_rx = 1'b1;
        tick(3);
        reset_in = 1'b0;
        tick(20);
        rx_ready = 1'b1;
        clr();
        send(8'hC3, 1'b1);
        tick(4);
        expect_got("t6_data", '{8'hC3});
        check("t6_ferr", fe_cnt, 0);
        check("excl", excl_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
